sprite_plotter: RTL and testbench
=================================

Name: sprite_plotter

Overview:
- Draw datapath that sits directly downstream of the pet-state control FSM.
- On a one-cycle start strobe it blits a SPRITE_W x SPRITE_H sprite from an external synchronous sprite ROM to the VGA adapter at a latched origin, one pixel per clock.
- On a clear strobe it sweeps the whole screen with black.
- It reports busy and a one-cycle done pulse back to the control FSM.

Parameters:
- X_SCREEN_PIXELS, 160, screen width in pixels.
- Y_SCREEN_PIXELS, 120, screen height in pixels.
- SPRITE_W, 16, sprite width; power of two.
- SPRITE_H, 16, sprite height; power of two.
- COLOUR_W, 3, colour bits per pixel.
- TRANSPARENT, 3'b101, ROM colour value that is never plotted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to draw the selected sprite.
- clear  in  1  one-cycle request to blank the full screen.
- x_origin  in  8  sprite top-left x; sampled on start acceptance.
- y_origin  in  7  sprite top-left y; sampled on start acceptance.
- sprite_sel  in  2  sprite index; sampled on start acceptance.
- rom_addr  out  10  {sprite_sel, row[3:0], col[3:0]}; ROM returns data one cycle later.
- rom_data  in  COLOUR_W  sprite ROM read data.
- vga_x  out  8  pixel x to the VGA adapter.
- vga_y  out  7  pixel y to the VGA adapter.
- vga_colour  out  COLOUR_W  pixel colour to the VGA adapter.
- vga_plot  out  1  write enable to the VGA adapter.
- busy  out  1  high while a draw or clear is in progress.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset has priority over everything, including mid-operation; no further plots after the reset edge.
- States:
  - IDLE → CLEAR when clear=1.
  - IDLE → FETCH when start=1 and clear=0. Clear wins if both are high in the same cycle.
  - FETCH → DRAW: lasts 1 cycle and issues the ROM address for pixel (0,0).
  - DRAW: each cycle issues the next address and plots the previous pixel. Goes to DONE after the plot of pixel (SPRITE_W-1, SPRITE_H-1).
  - CLEAR: one pixel per cycle in raster order, x fastest, colour 0, vga_plot=1. Goes to DONE after (X_SCREEN_PIXELS-1, Y_SCREEN_PIXELS-1).
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Start timing: accepted at cycle 0; busy rises at cycle 1. Pixel (c,r) is plotted at cycle 2 + r*SPRITE_W + c, i.e. cycles 2..257 for 16x16. done=1 at cycle 258.
- Clear timing: accepted at cycle 0. Pixel (x,y) is plotted at cycle 1 + y*X_SCREEN_PIXELS + x, i.e. cycles 1..19200. done=1 at cycle 19201.
- Coordinate pipeline:
  - vga_x = x_origin + col and vga_y = y_origin + row.
  - Both are computed 1 bit wider than their outputs, with no wrap.
  - Coordinates are registered alongside the ROM access so they align with rom_data.
- Plot suppression: vga_plot=0 for a pixel if rom_data == TRANSPARENT, or sum_x >= X_SCREEN_PIXELS, or sum_y >= Y_SCREEN_PIXELS (clipping). Timing is unchanged; the pixel slot is still consumed.
- vga_colour = rom_data during DRAW, 0 during CLEAR, and holds its last value when vga_plot=0.
- start while busy: ignored, not queued.
- clear during FETCH or DRAW: aborts the sprite and enters CLEAR on the next cycle, restarting at (0,0). Exactly one done pulse, at the end of the clear.
- clear during CLEAR: ignored.
- Origin inputs changing mid-draw have no effect; values are latched at acceptance.

Test Plan:
1. Reset, then start with x_origin=10, y_origin=20, sprite_sel=1, and a ROM returning opaque colour 3'b010:
   - 256 plots on cycles 2..257.
   - First plot at (10,20) with rom_addr 0x100 on cycle 1.
   - Last plot at (25,35).
   - done on cycle 258 only.
2. Start with x_origin=150, y_origin=112:
   - vga_plot is high only for x ≤ 159 and y ≤ 119, i.e. 10x8 = 80 plots.
   - done still on cycle 258.
3. ROM returns TRANSPARENT for every even column:
   - exactly 128 plots.
   - no plot ever carries colour 3'b101.
4. clear pulse:
   - 19200 consecutive plots with colour 0.
   - first at (0,0), cycle 1; (159,0) then (0,1) on cycles 160/161; last at (159,119).
   - done on cycle 19201.
5. start and clear in the same cycle → clear sequence only. Then clear at cycle 50 of a draw → plotting restarts at (0,0) on cycle 51, with one done at the end.
6. reset asserted at cycle 100 of a draw → at the next edge busy=0, vga_plot=0, done=0. Then a new start runs a complete draw.

Source files
------------

// File: rtl/sprite_plotter.sv
// Sprite blitter and full-screen clear engine feeding a VGA adapter.
// One pixel per clock; sprite ROM has one cycle of read latency.
module sprite_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int COLOUR_W = 3,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic [7:0]          x_origin,
    input  logic [6:0]          y_origin,
    input  logic [1:0]          sprite_sel,
    output logic [9:0]          rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);
    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int PIX_W = COL_W + ROW_W;
    localparam logic [8:0] X_LIM = 9'(X_SCREEN_PIXELS);
    localparam logic [7:0] Y_LIM = 8'(Y_SCREEN_PIXELS);
    localparam logic [7:0] CX_MAX = 8'(X_SCREEN_PIXELS - 1);
    localparam logic [6:0] CY_MAX = 7'(Y_SCREEN_PIXELS - 1);
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {IDLE, FETCH, DRAW, CLEAR, DONE} state_t;

    state_t               state, state_next;
    logic [1:0]           sel_q;
    logic [7:0]           x_org;
    logic [6:0]           y_org;
    logic [PIX_W-1:0]     pix;
    logic [8:0]           px;
    logic [7:0]           py;
    logic                 p_last;
    logic [7:0]           cx;
    logic [6:0]           cy;
    logic [COLOUR_W-1:0]  colour_q;
    logic                 draw_plot;
    logic                 clear_last;

    assign rom_addr = {sel_q, pix};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel_q    <= '0;
            x_org    <= '0;
            y_org    <= '0;
            pix      <= '0;
            px       <= '0;
            py       <= '0;
            p_last   <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            colour_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start && !clear) begin
                sel_q <= sprite_sel;
                x_org <= x_origin;
                y_org <= y_origin;
                pix   <= '0;
            end
            // Coordinates of the address issued this cycle ride alongside the ROM read.
            if (state == FETCH || state == DRAW) begin
                px     <= {1'b0, x_org} + 9'(pix[COL_W-1:0]);
                py     <= {1'b0, y_org} + 8'(pix[PIX_W-1:COL_W]);
                p_last <= (pix == PIX_MAX);
                pix    <= pix + PIX_W'(1);
            end
            if (state == CLEAR) begin
                cx <= (cx == CX_MAX) ? '0 : cx + 8'd1;
                if (cx == CX_MAX)
                    cy <= (cy == CY_MAX) ? '0 : cy + 7'd1;
            end else begin
                cx <= '0;
                cy <= '0;
            end
            if (draw_plot)
                colour_q <= rom_data;
            else if (state == CLEAR)
                colour_q <= '0;
        end
    end

    always_comb begin
        state_next = state;
        draw_plot  = (state == DRAW) && (rom_data != TRANSPARENT) && (px < X_LIM) && (py < Y_LIM);
        clear_last = (cx == CX_MAX) && (cy == CY_MAX);
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = colour_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (clear)
                    state_next = CLEAR;
                else if (start)
                    state_next = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = clear ? CLEAR : DRAW;
            end
            DRAW: begin
                busy     = 1'b1;
                vga_plot = draw_plot;
                vga_x    = px[7:0];
                vga_y    = py[6:0];
                if (draw_plot)
                    vga_colour = rom_data;
                if (clear)
                    state_next = CLEAR;
                else if (p_last)
                    state_next = DONE;
            end
            CLEAR: begin
                busy       = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = cx;
                vga_y      = cy;
                vga_colour = '0;
                if (clear_last)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: a ROM model, a plot scoreboard,
// a table of draw vectors, and hand-written clear/abort/reset sequences.
module tb_sprite_plotter;
    logic       clk = 1'b0;
    logic       reset, start, clear;
    logic [7:0] x_origin;
    logic [6:0] y_origin;
    logic [1:0] sprite_sel;
    logic [9:0] rom_addr;
    logic [2:0] rom_data = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    sprite_plotter #(.X_SCREEN_PIXELS(160), .Y_SCREEN_PIXELS(120), .SPRITE_W(16),
                     .SPRITE_H(16), .COLOUR_W(3), .TRANSPARENT(3'b101)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .x_origin(x_origin), .y_origin(y_origin), .sprite_sel(sprite_sel),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM model: mode 0 opaque 3'b010, mode 1 transparent on even
    // columns, mode 2 colour = col[2:0] ^ sel.
    int rom_mode = 0;
    function automatic logic [2:0] rom_model(int mode, int sel, int c);
        case (mode)
            0: return 3'b010;
            1: return (c % 2 == 0) ? 3'b101 : 3'b011;
            default: return 3'(c % 8) ^ 3'(sel);
        endcase
    endfunction
    always @(posedge clk) rom_data <= rom_model(rom_mode, int'(rom_addr[9:8]), int'(rom_addr[3:0]));

    typedef struct {int rel; int x; int y; int colour;} plot_t;
    typedef struct {logic [7:0] x; logic [6:0] y; logic [1:0] sel; int mode; int plots;} vec_t;

    plot_t      exp_q[$];
    vec_t       vecs[6];
    int         checks = 0, failures = 0;
    int         t0 = 0, done_count = 0, done_rel = -1, plot_count = 0;
    logic [9:0] addr1;
    logic       busy1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc - t0);
        end
    endtask

    function automatic logic [63:0] pack(int r, int x, int y, int c);
        return {24'(r), 16'(x), 16'(y), 8'(c)};
    endfunction

    always @(negedge clk) begin
        int rel;
        plot_t e;
        rel = cyc - t0;
        if (rel == 1) begin
            addr1 = rom_addr;
            busy1 = busy;
        end
        if (done) begin
            done_count++;
            done_rel = rel;
        end
        if (vga_plot) begin
            plot_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL plot_extra got=(%0d,%0d) c=%0d at cycle %0d, none expected",
                         vga_x, vga_y, vga_colour, rel);
            end else begin
                e = exp_q.pop_front();
                check("plot", pack(rel, vga_x, vga_y, vga_colour), pack(e.rel, e.x, e.y, e.colour));
            end
        end
    end

    task automatic begin_op();
        t0 = cyc;
        done_count = 0;
        done_rel = -1;
        plot_count = 0;
        addr1 = '0;
        busy1 = 1'b0;
    endtask

    task automatic push_draw(input int x, input int y, input int sel, input int mode, input int max_rel);
        for (int k = 0; k < 256; k++) begin
            int c, r, col;
            c = k % 16;
            r = k / 16;
            col = int'(rom_model(mode, sel, c));
            if (2 + k <= max_rel && col != 5 && x + c < 160 && y + r < 120)
                exp_q.push_back('{2 + k, x + c, y + r, col});
        end
    endtask

    task automatic push_clear(input int base);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back('{base + 1 + y * 160 + x, x, y, 0});
    endtask

    task automatic finish_op(input string name, input int exp_done, input int exp_plots);
        check({name, "_done_count"}, done_count, 1);
        check({name, "_done_cycle"}, done_rel, exp_done);
        check({name, "_plot_count"}, plot_count, exp_plots);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic run_draw(input vec_t v);
        begin_op();
        rom_mode = v.mode;
        x_origin = v.x;
        y_origin = v.y;
        sprite_sel = v.sel;
        start = 1'b1;
        push_draw(v.x, v.y, v.sel, v.mode, 1000);
        @(negedge clk);
        start = 1'b0;
        x_origin = ~v.x;
        y_origin = ~v.y;
        sprite_sel = ~v.sel;
        repeat (99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (160) @(negedge clk);
        check("draw_rom_addr_c1", addr1, {v.sel, 8'h00});
        check("draw_busy_c1", busy1, 1);
        finish_op("draw", 258, v.plots);
    endtask

    initial begin
        vecs[0] = '{8'd10,  7'd20,  2'd1, 0, 256};
        vecs[1] = '{8'd150, 7'd112, 2'd0, 0, 80};
        vecs[2] = '{8'd40,  7'd30,  2'd2, 1, 128};
        vecs[3] = '{8'd0,   7'd0,   2'd3, 2, 224};
        vecs[4] = '{8'd255, 7'd127, 2'd1, 0, 0};
        vecs[5] = '{8'd144, 7'd104, 2'd0, 2, 224};

        reset = 1'b1; start = 1'b0; clear = 1'b0;
        x_origin = '0; y_origin = '0; sprite_sel = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_plot", vga_plot, 0);
        check("reset_x", vga_x, 0);
        check("reset_y", vga_y, 0);
        check("reset_colour", vga_colour, 0);
        check("reset_rom_addr", rom_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_draw(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Plain clear, with a redundant clear pulse mid-sweep.
        begin_op();
        clear = 1'b1;
        push_clear(0);
        @(negedge clk);
        clear = 1'b0;
        repeat (4999) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (19204 - 5001) @(negedge clk);
        check("clear_busy_c1", busy1, 1);
        finish_op("clear", 19201, 19200);
        repeat (2) @(negedge clk);

        // Start and clear together: clear wins.
        begin_op();
        rom_mode = 0;
        x_origin = 8'd10; y_origin = 7'd20; sprite_sel = 2'd1;
        start = 1'b1; clear = 1'b1;
        push_clear(0);
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        repeat (19203) @(negedge clk);
        finish_op("both", 19201, 19200);
        repeat (2) @(negedge clk);

        // Clear at cycle 50 of a draw aborts it.
        begin_op();
        start = 1'b1;
        push_draw(10, 20, 1, 0, 50);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        clear = 1'b1;
        push_clear(50);
        @(negedge clk);
        clear = 1'b0;
        repeat (19203) @(negedge clk);
        finish_op("abort", 19251, 49 + 19200);
        repeat (2) @(negedge clk);

        // Reset at cycle 100 of a draw.
        begin_op();
        start = 1'b1;
        push_draw(10, 20, 1, 0, 100);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_plot", vga_plot, 0);
        check("midreset_done", done, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_plot_count", plot_count, 99);
        check("midreset_queue_left", exp_q.size(), 0);
        check("midreset_no_done", done_count, 0);
        run_draw(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
